dir_sector_builder: RTL and testbench

DIR_SECTOR_BUILDER -- requirements
Module: dir_sector_builder

---
 rtl/dir_sector_pkg.sv | 22 ++
 rtl/dir_sector_builder_if.sv | 31 +++
 rtl/dir_sector_builder_lfn_checksum_acc.sv | 26 ++
 rtl/dir_sector_builder.sv | 138 +++++++++++++
 tb/tb_dir_sector_builder.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dir_sector_pkg.sv
// Shared constants, state encoding and entry byte helper for the FAT32
// directory sector builder.
package dir_sector_pkg;

    localparam int SECTOR_BYTES = 512;
    localparam int ENTRY_BYTES  = 32;
    localparam int ENTRY_W      = ENTRY_BYTES * 8;
    localparam int ATTR_OFFSET  = 11;
    localparam logic [7:0] ATTR_LFN = 8'h0F;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAD  = 2'd2
    } state_t;

    // Long-name entries carry the 0x0F attribute byte; everything else is short.
    function automatic logic is_short_entry(input logic [ENTRY_W-1:0] e);
        return e[8*ATTR_OFFSET +: 8] != ATTR_LFN;
    endfunction

endpackage

// File: rtl/dir_sector_builder_if.sv
// Entry-in / sector-byte-out bundle of the directory sector builder.
// master = entry producer plus SD writer side, slave = the builder.
interface dir_sector_builder_if;
    import dir_sector_pkg::*;

    logic               entry_valid;
    logic               entry_ready;
    logic [ENTRY_W-1:0] entry_data;
    logic               entry_last;
    logic               flush;
    logic               byte_valid;
    logic               byte_ready;
    logic [7:0]         byte_data;
    logic               byte_last;
    logic               sector_done;
    logic [7:0]         sfn_checksum;
    logic               checksum_valid;

    modport master (
        output entry_valid, entry_data, entry_last, flush, byte_ready,
        input  entry_ready, byte_valid, byte_data, byte_last, sector_done,
               sfn_checksum, checksum_valid
    );

    modport slave (
        input  entry_valid, entry_data, entry_last, flush, byte_ready,
        output entry_ready, byte_valid, byte_data, byte_last, sector_done,
               sfn_checksum, checksum_valid
    );

endinterface

// File: rtl/dir_sector_builder_lfn_checksum_acc.sv
// Rotate-right-and-add accumulator for the VFAT short-name checksum.
module lfn_checksum_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       step,
    input  logic [7:0] din,
    output logic [7:0] sum,
    output logic [7:0] sum_next
);

    always_comb begin
        sum_next = {sum[0], sum[7:1]} + din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (step) begin
            sum <= sum_next;
        end
    end

endmodule

// File: rtl/dir_sector_builder.sv
// Serialises 32-byte FAT32 directory entries into zero-padded SD sectors
// and reports the short-name checksum of each short entry streamed out.
module dir_sector_builder #(
    parameter int SECTOR_BYTES = dir_sector_pkg::SECTOR_BYTES,
    parameter int ENTRY_BYTES  = dir_sector_pkg::ENTRY_BYTES
) (
    input logic                 clk,
    input logic                 rst_n,
    dir_sector_builder_if.slave bus
);
    import dir_sector_pkg::*;

    localparam int CW = $clog2(SECTOR_BYTES);
    localparam int IW = $clog2(ENTRY_BYTES);

    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [ENTRY_W-1:0] ent;
    logic               ent_last;
    logic               alive;
    logic               done_q, done_n;
    logic [7:0]         sfn_q;
    logic               cs_pulse;

    logic       ready, bvalid, hs, accept, flush_go;
    logic       cnt_last, idx_last, short_ent, cs_step, cs_capture;
    logic [7:0] bdata, cur_byte, sum, sum_next;

    always_comb begin
        cnt_last  = cnt == CW'(SECTOR_BYTES - 1);
        idx_last  = idx == IW'(ENTRY_BYTES - 1);
        short_ent = is_short_entry(ent);
        cur_byte  = ent[{idx, 3'b000} +: 8];
        // Flush only matters in IDLE with a partially filled sector, and it
        // blocks entry acceptance in that same cycle.
        flush_go  = alive && (state == IDLE) && bus.flush && (cnt != '0);
    end

    always_comb begin
        state_n = state;
        ready   = 1'b0;
        bvalid  = 1'b0;
        bdata   = '0;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                ready = alive && !flush_go;
                if (flush_go) begin
                    state_n = PAD;
                end else if (alive && bus.entry_valid) begin
                    state_n = SEND;
                end
            end
            SEND: begin
                bvalid = 1'b1;
                bdata  = cur_byte;
                if (bus.byte_ready && idx_last) begin
                    if (cnt_last) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else if (ent_last) begin
                        state_n = PAD;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            PAD: begin
                bvalid = 1'b1;
                if (bus.byte_ready && cnt_last) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        hs         = bvalid && bus.byte_ready;
        accept     = ready && bus.entry_valid;
        cs_step    = hs && (state == SEND) && short_ent && (idx < IW'(ATTR_OFFSET));
        cs_capture = hs && (state == SEND) && short_ent && (idx == IW'(ATTR_OFFSET - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            idx      <= '0;
            ent      <= '0;
            ent_last <= 1'b0;
            alive    <= 1'b0;
            done_q   <= 1'b0;
            sfn_q    <= '0;
            cs_pulse <= 1'b0;
        end else begin
            state    <= state_n;
            alive    <= 1'b1;
            done_q   <= done_n;
            cs_pulse <= cs_capture;
            if (accept) begin
                ent      <= bus.entry_data;
                ent_last <= bus.entry_last;
                idx      <= '0;
            end
            if (hs) begin
                cnt <= cnt_last ? '0 : cnt + 1'b1;
                if (state == SEND) begin
                    idx <= idx + 1'b1;
                end
            end
            if (cs_capture) begin
                sfn_q <= sum_next;
            end
        end
    end

    lfn_checksum_acc u_acc (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .step     (cs_step),
        .din      (cur_byte),
        .sum      (sum),
        .sum_next (sum_next)
    );

    assign bus.entry_ready    = ready;
    assign bus.byte_valid     = bvalid;
    assign bus.byte_data      = bdata;
    assign bus.byte_last      = bvalid && cnt_last;
    assign bus.sector_done    = done_q;
    assign bus.sfn_checksum   = sfn_q;
    assign bus.checksum_valid = cs_pulse;

endmodule

// File: tb/tb_dir_sector_builder.sv
// Randomised bench for dir_sector_builder: a byte-queue model predicts the
// sector stream, handshakes and checksum pulses cycle by cycle.
module tb_dir_sector_builder;
    import dir_sector_pkg::*;

    localparam int SB = 512;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dir_sector_builder_if bus ();

    dir_sector_builder #(.SECTOR_BYTES(SB), .ENTRY_BYTES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state: q holds every byte still owed to the SD writer.
    logic [7:0] q[$];
    logic [7:0] obs[$];
    int   fill = 0, last_idx = -1, done_cnt = 0, cs_cnt = 0, cs_left = 0;
    logic [7:0] cs_val = '0, cs_calc = '0, prev_data = '0;
    bit   alive = 0, done_exp = 0, cs_pulse_exp = 0, prev_stall = 0, stall = 0;

    function automatic logic [7:0] sfn_sum(input logic [255:0] e);
        logic [7:0] s = '0;
        for (int i = 0; i < 11; i++) begin
            s = 8'((s >> 1) + ((s & 8'h01) != 0 ? 8'h80 : 8'h00) + e[8*i +: 8]);
        end
        return s;
    endfunction

    function automatic logic [255:0] splat(input logic [7:0] v);
        return {32{v}};
    endfunction

    function automatic logic [255:0] rnd_entry();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    always @(negedge clk) begin : compare
        bit exp_ready, exp_valid;
        if (!rst_n) begin
            chk("rst_entry_ready", bus.entry_ready, 0);
            chk("rst_byte_valid", bus.byte_valid, 0);
            chk("rst_byte_data", bus.byte_data, 0);
            chk("rst_byte_last", bus.byte_last, 0);
            chk("rst_sector_done", bus.sector_done, 0);
            chk("rst_sfn", bus.sfn_checksum, 0);
            chk("rst_cs_valid", bus.checksum_valid, 0);
            q.delete();
            fill = 0; alive = 0; done_exp = 0; cs_pulse_exp = 0;
            cs_val = '0; cs_left = 0; prev_stall = 0;
        end else begin
            exp_valid = q.size() != 0;
            exp_ready = alive && !exp_valid && !(bus.flush && fill != 0);
            chk("entry_ready", bus.entry_ready, exp_ready);
            chk("byte_valid", bus.byte_valid, exp_valid);
            if (exp_valid) begin
                chk("byte_data", bus.byte_data, q[0]);
                chk("byte_last", bus.byte_last, fill == SB - 1);
            end else begin
                chk("byte_last_idle", bus.byte_last, 0);
            end
            chk("sector_done", bus.sector_done, done_exp);
            chk("checksum_valid", bus.checksum_valid, cs_pulse_exp);
            chk("sfn_checksum", bus.sfn_checksum, cs_val);
            if (prev_stall) begin
                chk("stall_hold_data", bus.byte_data, prev_data);
            end
            if (bus.sector_done) done_cnt++;
            if (bus.checksum_valid) cs_cnt++;

            prev_stall = exp_valid && !bus.byte_ready;
            prev_data = bus.byte_data;
            done_exp = 0;
            cs_pulse_exp = 0;
            if (exp_valid && bus.byte_ready) begin
                obs.push_back(bus.byte_data);
                if (bus.byte_last) last_idx = obs.size() - 1;
                void'(q.pop_front());
                fill++;
                if (cs_left > 0) begin
                    cs_left--;
                    if (cs_left == 0) begin
                        cs_val = cs_calc;
                        cs_pulse_exp = 1;
                    end
                end
                if (fill == SB) begin
                    fill = 0;
                    done_exp = 1;
                end
            end else if (alive && !exp_valid && bus.flush && fill != 0) begin
                repeat (SB - fill) q.push_back(8'h00);
            end else if (exp_ready && bus.entry_valid) begin
                for (int i = 0; i < 32; i++) q.push_back(bus.entry_data[8*i +: 8]);
                if (bus.entry_last && fill + 32 < SB) repeat (SB - fill - 32) q.push_back(8'h00);
                if (bus.entry_data[95:88] != 8'h0F) begin
                    cs_left = 11;
                    cs_calc = sfn_sum(bus.entry_data);
                end else begin
                    cs_left = 0;
                end
            end
            alive = 1;
        end
    end

    initial begin : ready_drv
        bus.byte_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.byte_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_entry(input logic [255:0] d, input logic last);
        bit ok = 0;
        bus.entry_data = d;
        bus.entry_last = last;
        bus.entry_valid = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            ok = bus.entry_ready;
            tick();
        end
        bus.entry_valid = 1'b0;
        bus.entry_last = 1'b0;
        if (!ok) chk("entry_accept_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            ok = (q.size() == 0) && !done_exp;
        end
        #1;
        tick();
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic do_flush();
        int d0 = done_cnt;
        bit ok = 0;
        bus.flush = 1'b1;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(posedge clk);
            ok = done_cnt > d0;
        end
        #1;
        bus.flush = 1'b0;
        if (!ok) chk("flush_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int d0, c0, bad, sz;
        logic [255:0] e;
        bus.entry_valid = 1'b0;
        bus.entry_last = 1'b0;
        bus.entry_data = '0;
        bus.flush = 1'b0;

        repeat (3) tick();
        chk("reset_ready_low", bus.entry_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_first_clk", bus.entry_ready, 0);
        @(negedge clk);
        chk("ready_after_first_clk", bus.entry_ready, 1);
        tick();

        // Sixteen full entries fill the sector exactly; last on the 16th adds no pad.
        obs.delete(); d0 = done_cnt;
        for (int n = 0; n < 16; n++) send_entry(splat(8'(n)), n == 15);
        wait_idle();
        chk("full_size", obs.size(), 512);
        bad = 0;
        for (int i = 0; i < obs.size(); i++) if (obs[i] != 8'(i / 32)) bad++;
        chk("full_order", bad, 0);
        chk("full_last_idx", last_idx, 511);
        chk("full_done", done_cnt - d0, 1);

        // One entry with last: 32 data bytes then 480 zeros.
        obs.delete(); d0 = done_cnt; e = rnd_entry();
        send_entry(e, 1'b1);
        wait_idle();
        chk("pad_size", obs.size(), 512);
        bad = 0;
        for (int i = 0; i < 32; i++) if (obs[i] != e[8*i +: 8]) bad++;
        chk("pad_entry_bytes", bad, 0);
        bad = 0;
        for (int i = 32; i < obs.size(); i++) if (obs[i] != 8'h00) bad++;
        chk("pad_zero_bytes", bad, 0);
        chk("pad_last_idx", last_idx, 511);
        chk("pad_done", done_cnt - d0, 1);

        // Checksum: 0x01 then ten zeros rotates to 0x40; long entry leaves it alone.
        c0 = cs_cnt; e = rnd_entry();
        e[87:0] = '0; e[7:0] = 8'h01; e[95:88] = 8'h20;
        chk("model_sfn_pin", sfn_sum(e), 8'h40);
        send_entry(e, 1'b0);
        wait_idle();
        chk("sfn_value", bus.sfn_checksum, 8'h40);
        chk("sfn_pulses", cs_cnt - c0, 1);
        e = rnd_entry(); e[95:88] = 8'h0F;
        send_entry(e, 1'b0);
        wait_idle();
        chk("lfn_no_pulse", cs_cnt - c0, 1);
        chk("lfn_value_held", bus.sfn_checksum, 8'h40);
        do_flush();
        wait_idle();

        // Three entries then flush racing an offered entry: 416 pad bytes.
        obs.delete(); d0 = done_cnt;
        for (int n = 0; n < 3; n++) send_entry(rnd_entry(), 1'b0);
        bus.flush = 1'b1;
        bus.entry_data = rnd_entry();
        bus.entry_last = 1'b0;
        bus.entry_valid = 1'b1;
        for (int i = 0; i < 4000 && done_cnt == d0; i++) @(posedge clk);
        chk("flush_size", obs.size(), 512);
        bad = 0;
        for (int i = 96; i < obs.size(); i++) if (obs[i] != 8'h00) bad++;
        chk("flush_zero_bytes", bad, 0);
        chk("flush_pad_count", obs.size() - 96, 416);
        #1;
        bus.entry_valid = 1'b0;
        bus.flush = 1'b0;
        wait_idle();
        if (fill != 0) do_flush();
        wait_idle();
        sz = obs.size(); d0 = done_cnt;
        bus.flush = 1'b1;
        repeat (20) tick();
        bus.flush = 1'b0;
        chk("flush_zero_no_bytes", obs.size(), sz);
        chk("flush_zero_no_done", done_cnt, d0);

        // Random stalls and random mix of entries, last flags and flushes.
        stall = 1;
        for (int n = 0; n < 25; n++) begin
            int r = $urandom_range(0, 7);
            if (r == 0) begin
                wait_idle();
                if (fill != 0) do_flush();
            end else begin
                send_entry(rnd_entry(), r == 1);
            end
        end
        wait_idle();
        if (fill != 0) do_flush();
        wait_idle();
        stall = 0;
        repeat (2) tick();

        // Reset at roughly sector byte 200, then a fresh sector.
        obs.delete();
        for (int n = 0; n < 7; n++) send_entry(rnd_entry(), 1'b0);
        for (int i = 0; i < 4000 && obs.size() < 200; i++) @(posedge clk);
        #1;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("midrst_byte_valid", bus.byte_valid, 0);
        chk("midrst_entry_ready", bus.entry_ready, 0);
        chk("midrst_byte_data", bus.byte_data, 0);
        chk("midrst_sfn", bus.sfn_checksum, 0);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("midrst_no_done", done_cnt, d0);
        obs.delete();
        send_entry(rnd_entry(), 1'b1);
        wait_idle();
        chk("fresh_size", obs.size(), 512);
        chk("fresh_last_idx", last_idx, 511);
        chk("fresh_done", done_cnt - d0, 1);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
